// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter: sequencer states,
// requester port indices and the legal read-latency window.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] PORT_LOAD  = 2'd0;  // program loader / debug
    localparam logic [1:0] PORT_DMEM  = 2'd1;  // CPU data access
    localparam logic [1:0] PORT_IMEM  = 2'd2;  // CPU instruction fetch
    localparam logic [1:0] GRANT_NONE = 2'd3;

    localparam int NUM_PORTS    = 3;
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 7;

    // One-hot completion vector for a port index; GRANT_NONE maps to zero.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] idx);
        logic [NUM_PORTS-1:0] oh;
        oh = '0;
        case (idx)
            PORT_LOAD: oh = 3'b001;
            PORT_DMEM: oh = 3'b010;
            PORT_IMEM: oh = 3'b100;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Winner select for three requesters: port 0 always wins, ports 1 and 2
// alternate, the one not served last taking a tie.
module rr_pick3
    import mem_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_last,
    output logic       valid,
    output logic [1:0] idx
);

    // Fixed priority for the loader, round-robin between the two CPU ports.
    always_comb begin
        valid = |req;
        idx   = GRANT_NONE;
        if (req[PORT_LOAD]) begin
            idx = PORT_LOAD;
        end else if (req[PORT_DMEM] && req[PORT_IMEM]) begin
            idx = (rr_last == PORT_DMEM) ? PORT_IMEM : PORT_DMEM;
        end else if (req[PORT_DMEM]) begin
            idx = PORT_DMEM;
        end else if (req[PORT_IMEM]) begin
            idx = PORT_IMEM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the multicycle CPU: one transaction in
// flight, sequenced as arbitrate (IDLE), strobe (ISSUE), read latency (WAIT)
// and a one-cycle completion pulse (RESP). All outputs are registered.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    output logic [2:0]    done,
    output logic [DW-1:0] rdata,
    output logic [1:0]    grant,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Counter preload: number of WAIT cycles between the strobe and capture.
    localparam logic [2:0] LAT_LOAD = 3'(READ_LAT - 1);

    if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_lat_check
        $error("mem_port_arbiter: READ_LAT must be within 1..7");
    end

    state_t        state;
    logic [2:0]    cnt;
    logic [1:0]    rr_last;
    logic          op_we;

    logic          pick_valid;
    logic [1:0]    pick_idx;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    rr_pick3 u_pick (
        .req     (req),
        .rr_last (rr_last),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Route the winning port's operands toward the capture registers.
    always_comb begin
        sel_we    = we[0];
        sel_addr  = addr[0 +: AW];
        sel_wdata = wdata[0 +: DW];
        case (pick_idx)
            PORT_DMEM: begin
                sel_we    = we[1];
                sel_addr  = addr[AW +: AW];
                sel_wdata = wdata[DW +: DW];
            end
            PORT_IMEM: begin
                sel_we    = we[2];
                sel_addr  = addr[2*AW +: AW];
                sel_wdata = wdata[2*DW +: DW];
            end
            default: ;
        endcase
    end

    // Transaction sequencer. mem_addr/mem_wdata double as the latched operand
    // registers, so operand changes after the IDLE sample never reach memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= '0;
            rdata     <= '0;
            grant     <= GRANT_NONE;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rr_last   <= PORT_IMEM;
            cnt       <= '0;
            op_we     <= 1'b0;
        end else begin
            done   <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_idx;
                        op_we     <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        busy      <= 1'b1;
                        if (pick_idx != PORT_LOAD)
                            rr_last <= pick_idx;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (op_we) begin
                        done  <= port_onehot(grant);
                        state <= RESP;
                    end else if (READ_LAT == 1) begin
                        // Data is already valid during the strobe cycle.
                        rdata <= mem_rdata;
                        done  <= port_onehot(grant);
                        state <= RESP;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Capture on the edge where the counter reaches zero.
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rdata <= mem_rdata;
                        done  <= port_onehot(grant);
                        state <= RESP;
                    end
                end
                RESP: begin
                    grant <= GRANT_NONE;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between three requesters: port 0 program loader/debug, port 1 CPU data access (MEM state), port 2 CPU instruction fetch (IF state).
- Sits between the multicycle CPU control/datapath and the memory macro.
- Sequences each access as arbitrate, issue, wait for read latency, respond.
- Handles at most one transaction in flight.

Parameters:
AW, 10, word-address width of the memory
DW, 32, data width
READ_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..7

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req  in  3  per-port request, bit i = port i; held high until done[i]
we  in  3  per-port write enable, qualified by req
addr  in  3*AW  per-port word address, port i at [i*AW +: AW]
wdata  in  3*DW  per-port write data, port i at [i*DW +: DW]
done  out  3  one-cycle completion pulse, one-hot or zero
rdata  out  DW  read data for the completed port, valid while done is high
grant  out  2  index of the port owning the memory; 3 = none
busy  out  1  high in any state other than IDLE
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid READ_LAT cycles after a read strobe

Behaviour:
- Reset values: state = IDLE; done = 0; rdata = 0; grant = 3; busy = 0; mem_en = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; rr_last = 2.
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples req.
  - If any bit is set, registers the winner's index, we, addr and wdata, sets grant, then goes to ISSUE.
  - Otherwise stays in IDLE.
- Arbitration:
  - Port 0 has absolute priority.
  - Ports 1 and 2 alternate round-robin. rr_last records the last served of {1,2}, and on a 1/2 tie the port not equal to rr_last wins.
  - rr_last updates only when port 1 or 2 is granted; a port 0 grant leaves it unchanged.
- ISSUE, exactly one cycle:
  - mem_en = 1, mem_we = latched we, and mem_addr/mem_wdata driven from the latched values.
  - A write goes to RESP.
  - A read loads the latency counter with READ_LAT-1. It goes to WAIT, or to RESP when READ_LAT = 1 after capturing mem_rdata at the following edge.
- WAIT:
  - mem_en = 0 and mem_we = 0.
  - The counter decrements each cycle.
  - When the counter reaches 0, mem_rdata is captured into rdata and the state goes to RESP.
- RESP, one cycle:
  - done[grant] = 1.
  - rdata holds the captured read data; it holds its previous value for writes.
  - Next state is IDLE; grant returns to 3 on entry to IDLE.
- Latency, with req first seen in IDLE at cycle t:
  - Write: ISSUE at t+1, done at t+2.
  - Read: ISSUE at t+1, done at t+2+READ_LAT-1 = t+1+READ_LAT (READ_LAT = 1 gives done at t+2).
  - Minimum spacing between back-to-back grants is 3 cycles (IDLE, ISSUE, RESP).
- Requester rule:
  - A requester deasserts req on the edge that ends its done cycle.
  - If req is still high in the following IDLE cycle, it is treated as a new request.
- Request and operand timing:
  - A req dropped mid-transaction does not abort it; done still pulses.
  - Requests arriving outside IDLE wait, and are not lost while held.
  - Operand changes after the IDLE sample are ignored.
- Reset mid-operation: returns to IDLE with the reset values on the next edge. An already-issued write is not undone. No done is produced for the aborted transaction.
- No address range check; mem_addr is the latched address unmodified.
- rdata is not cleared after RESP.

Decomposition:
- Shared header/package mem_arb_pkg holds:
  - State encodings: IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3.
  - Port indices: PORT_LOAD = 0, PORT_DMEM = 1, PORT_IMEM = 2, GRANT_NONE = 3.
  - READ_LAT bounds.
- Sub-module rr_pick3: combinational winner select from req[2:0] and rr_last, returning a valid flag and a 2-bit index.
- The sequencer, latency counter and operand registers stay in mem_port_arbiter.

Test Plan:
- Single port-2 read at addr 5, memory word 5 = 0xDEADBEEF, READ_LAT = 1 -> mem_en one cycle at t+1 with mem_addr = 5 and mem_we = 0; done = 3'b100 at t+2 with rdata = 0xDEADBEEF.
- Port-1 write addr 9 data 0x12345678 -> one mem_en/mem_we pulse with mem_addr = 9 and mem_wdata = 0x12345678; done = 3'b010 at t+2; a later port-2 read of addr 9 returns 0x12345678.
- req = 3'b110 held continuously from reset -> grants alternate 1,2,1,2 and done pulses alternate 3'b010/3'b100, spaced 3 cycles apart for writes.
- req = 3'b111 -> port 0 is served first; rr_last stays 2, so port 1 wins next, then port 2.
- READ_LAT = 4 read -> mem_en high for only 1 cycle, busy high for 5 cycles, done at t+5, rdata equals the memory word.
- Reset asserted while in WAIT -> next cycle state is IDLE, done = 0 throughout, grant = 3, busy = 0; the pending req is re-arbitrated after reset deasserts.
